// File: rtl/scratch_mem_responder.sv
// Scratch RAM responder: two registered read ports, one write port, and a
// one-word-per-cycle zero-fill sweep after reset and on every clear request.
module scratch_mem_responder #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 1024
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear_req,
  input  logic [ADDR_W-1:0] raddr0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              WE,
  output logic              busy,
  output logic              clear_done,
  output logic              oob_fault,
  output logic [ADDR_W:0]   wr_count
);
  // state | meaning
  // IDLE  | serving reads and writes
  // CLEAR | zero-fill sweep, one word per cycle; accesses ignored
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_A  = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]  CNT_MAX  = '1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  clr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic idle, sweep_end;
  logic w_in, r0_in, r1_in;
  logic wr_ok, byp0, byp1, oob_seen;

  assign idle      = (state == IDLE);
  assign sweep_end = (state == CLEAR) && (clr_ptr == LAST_PTR);
  assign w_in      = ({1'b0, waddr}  < DEPTH_A);
  assign r0_in     = ({1'b0, raddr0} < DEPTH_A);
  assign r1_in     = ({1'b0, raddr1} < DEPTH_A);
  assign wr_ok     = idle && WE && w_in;
  // Write-first: a read of the location being written returns the new data.
  assign byp0      = wr_ok && (raddr0 == waddr);
  assign byp1      = wr_ok && (raddr1 == waddr);
  assign oob_seen  = (WE && !w_in) || !r0_in || !r1_in;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= CLEAR;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (clear_req) state_nxt = CLEAR;
      CLEAR: if (clr_ptr == LAST_PTR) state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == CLEAR);
    clear_done = sweep_end;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)               clr_ptr <= '0;
    else if (state == CLEAR)    clr_ptr <= sweep_end ? '0 : clr_ptr + 1'b1;
    else                        clr_ptr <= '0;
  end

  // Array has no reset; the sweep is what makes its contents defined.
  always_ff @(posedge clock) begin
    if (state == CLEAR) mem[clr_ptr] <= '0;
    else if (wr_ok)     mem[waddr[IDX_W-1:0]] <= wdata;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdata0    <= '0;
      rdata1    <= '0;
      oob_fault <= 1'b0;
      wr_count  <= '0;
    end else if (!idle) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      rdata0 <= !r0_in ? '0 : (byp0 ? wdata : mem[raddr0[IDX_W-1:0]]);
      rdata1 <= !r1_in ? '0 : (byp1 ? wdata : mem[raddr1[IDX_W-1:0]]);
      if (clear_req) begin
        oob_fault <= 1'b0;
        wr_count  <= '0;
      end else begin
        if (oob_seen) oob_fault <= 1'b1;
        if (wr_ok && (wr_count != CNT_MAX)) wr_count <= wr_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_scratch_mem_responder.sv
// Randomized and directed bench for scratch_mem_responder (DEPTH=16, ADDR_W=5)
// against a per-cycle behavioural model of the scratch memory.
module tb_scratch_mem_responder;
  localparam int DW   = 128;
  localparam int AW   = 5;
  localparam int DP   = 16;
  localparam int CMAX = (1 << (AW + 1)) - 1;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          clear_req = 1'b0;
  logic          WE = 1'b0;
  logic [AW-1:0] raddr0 = '0, raddr1 = '0, waddr = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata0, rdata1;
  logic          busy, clear_done, oob_fault;
  logic [AW:0]   wr_count;

  always #5 clock = ~clock;

  scratch_mem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
    .clock(clock), .reset_n(reset_n), .clear_req(clear_req),
    .raddr0(raddr0), .raddr1(raddr1), .rdata0(rdata0), .rdata1(rdata1),
    .waddr(waddr), .wdata(wdata), .WE(WE),
    .busy(busy), .clear_done(clear_done), .oob_fault(oob_fault), .wr_count(wr_count)
  );

  // reference model: memory image, remaining sweep cycles, expected outputs
  logic [DW-1:0] m_mem [DP];
  int            m_left;
  logic [DW-1:0] m_rd0, m_rd1;
  logic          m_oob;
  int            m_wcnt;
  int            n_pass = 0, n_total = 0;

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic void model_reset();
    m_left = DP; m_rd0 = '0; m_rd1 = '0; m_oob = 1'b0; m_wcnt = 0;
  endfunction

  function automatic void model_step();
    int ra0, ra1, wa;
    bit wok;
    ra0 = int'(raddr0); ra1 = int'(raddr1); wa = int'(waddr);
    if (m_left > 0) begin
      m_mem[DP - m_left] = '0;
      m_left--;
      m_rd0 = '0; m_rd1 = '0;
    end else begin
      wok = WE && (wa < DP);
      m_rd0 = (ra0 >= DP) ? '0 : ((wok && wa == ra0) ? wdata : m_mem[ra0]);
      m_rd1 = (ra1 >= DP) ? '0 : ((wok && wa == ra1) ? wdata : m_mem[ra1]);
      if (wok) m_mem[wa] = wdata;
      if (clear_req) begin
        m_wcnt = 0; m_oob = 1'b0; m_left = DP;
      end else begin
        if (ra0 >= DP || ra1 >= DP || (WE && wa >= DP)) m_oob = 1'b1;
        if (wok && m_wcnt < CMAX) m_wcnt++;
      end
    end
  endfunction

  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    clear_req = 1'b0; WE = 1'b0; raddr0 = '0; raddr1 = '0; waddr = '0; wdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    n_total++;
    if (busy !== 1'b1 || clear_done !== 1'b0 || rdata0 !== '0 || rdata1 !== '0 ||
        oob_fault !== 1'b0 || wr_count !== '0)
      $display("FAIL reset_values: busy=%0b done=%0b rd0=%h rd1=%h oob=%0b cnt=%0d, want 1 0 0 0 0 0",
               busy, clear_done, rdata0, rdata1, oob_fault, wr_count);
    else n_pass++;
    reset_n = 1'b1;
  endtask

  task automatic test_sweep_length();
    int bc = 0;
    int dn = 0;
    for (int c = 1; c <= DP + 4; c++) begin
      n_total++;
      if (busy !== (m_left > 0) || clear_done !== (m_left == 1))
        $display("FAIL sweep_flags cyc %0d: busy=%0b done=%0b, want busy=%0b done=%0b",
                 c, busy, clear_done, m_left > 0, m_left == 1);
      else n_pass++;
      if (busy === 1'b1) bc++;
      if (clear_done === 1'b1) dn++;
      cycle();
    end
    n_total++;
    if (bc != DP || dn != 1)
      $display("FAIL sweep_length: busy_cycles=%0d done_pulses=%0d, want %0d 1", bc, dn, DP);
    else n_pass++;
    for (int a = 0; a < DP; a++) begin
      raddr0 = AW'(a); raddr1 = AW'(DP - 1 - a);
      cycle();
      n_total++;
      if (rdata0 !== m_rd0 || rdata1 !== m_rd1 || rdata0 !== '0)
        $display("FAIL sweep_zero addr %0d: rd0=%h rd1=%h, want %h %h", a, rdata0, rdata1, m_rd0, m_rd1);
      else n_pass++;
    end
    idle_inputs();
  endtask

  task automatic test_write_read();
    WE = 1'b1; waddr = 5'd3; wdata = {16{8'hA5}};
    cycle();
    WE = 1'b0; raddr0 = 5'd3;
    cycle();
    n_total++;
    if (rdata0 !== {16{8'hA5}} || rdata0 !== m_rd0 || wr_count !== (AW+1)'(m_wcnt) || wr_count !== 6'd1)
      $display("FAIL write_read: rd0=%h cnt=%0d, want %h %0d", rdata0, wr_count, m_rd0, m_wcnt);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_bypass();
    WE = 1'b1; waddr = 5'd5; wdata = 128'h1234; raddr0 = 5'd5; raddr1 = 5'd5;
    cycle();
    idle_inputs();
    n_total++;
    if (rdata0 !== 128'h1234 || rdata1 !== 128'h1234 || rdata0 !== m_rd0 || rdata1 !== m_rd1)
      $display("FAIL bypass: rd0=%h rd1=%h, want %h %h", rdata0, rdata1, m_rd0, m_rd1);
    else n_pass++;
  endtask

  task automatic test_oob();
    raddr0 = 5'd3; raddr1 = 5'd16;
    cycle();
    n_total++;
    if (rdata1 !== '0 || oob_fault !== 1'b1 || rdata0 !== m_rd0 || oob_fault !== m_oob)
      $display("FAIL oob_read: rd1=%h oob=%0b rd0=%h, want 0 1 %h", rdata1, oob_fault, rdata0, m_rd0);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      WE = 1'b1; waddr = AW'($urandom_range(0, DP - 1)); wdata = rnd_word();
      raddr0 = AW'($urandom_range(0, DP - 1)); raddr1 = AW'($urandom_range(0, DP - 1));
      cycle();
      n_total++;
      if (oob_fault !== 1'b1 || rdata0 !== m_rd0 || rdata1 !== m_rd1)
        $display("FAIL oob_sticky %0d: oob=%0b rd0=%h rd1=%h, want 1 %h %h", i, oob_fault, rdata0, rdata1, m_rd0, m_rd1);
      else n_pass++;
    end
    idle_inputs();
  endtask

  task automatic test_clear();
    int bc = 0;
    int dn = 0;
    logic [DW-1:0] x;
    WE = 1'b1; waddr = 5'd2; wdata = rnd_word(); cycle();
    waddr = 5'd9; wdata = rnd_word(); cycle();
    WE = 1'b0; raddr1 = 5'd20; cycle();
    // clear_req together with a write, a bypass read and an oob read
    x = rnd_word();
    clear_req = 1'b1; WE = 1'b1; waddr = 5'd9; wdata = x; raddr0 = 5'd9; raddr1 = 5'd21;
    cycle();
    n_total++;
    if (rdata0 !== x || oob_fault !== 1'b0 || wr_count !== '0 || busy !== 1'b1 || oob_fault !== m_oob)
      $display("FAIL clear_collide: rd0=%h oob=%0b cnt=%0d busy=%0b, want %h 0 0 1", rdata0, oob_fault, wr_count, busy, x);
    else n_pass++;
    idle_inputs();
    for (int k = 0; k < 40 && busy === 1'b1; k++) begin
      idle_inputs();
      if (k == 0) begin WE = 1'b1; waddr = 5'd2; wdata = {DW{1'b1}}; raddr0 = 5'd2; raddr1 = 5'd17; end
      if (k == 4) clear_req = 1'b1;
      if (clear_done === 1'b1) dn++;
      bc++;
      cycle();
      n_total++;
      if (rdata0 !== m_rd0 || rdata1 !== m_rd1 || oob_fault !== m_oob || busy !== (m_left > 0))
        $display("FAIL clear_busy k %0d: rd0=%h rd1=%h oob=%0b busy=%0b, want %h %h %0b %0b",
                 k, rdata0, rdata1, oob_fault, busy, m_rd0, m_rd1, m_oob, m_left > 0);
      else n_pass++;
    end
    idle_inputs();
    n_total++;
    if (bc != DP || dn != 1)
      $display("FAIL clear_length: busy_cycles=%0d done_pulses=%0d, want %0d 1", bc, dn, DP);
    else n_pass++;
    raddr0 = 5'd2; raddr1 = 5'd9;
    cycle();
    n_total++;
    if (rdata0 !== '0 || rdata1 !== '0 || wr_count !== '0 || oob_fault !== 1'b0 || rdata0 !== m_rd0)
      $display("FAIL clear_result: rd0=%h rd1=%h cnt=%0d oob=%0b, want 0 0 0 0", rdata0, rdata1, wr_count, oob_fault);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_saturate();
    for (int i = 0; i < CMAX + 8; i++) begin
      WE = 1'b1; waddr = AW'($urandom_range(0, DP - 1)); wdata = rnd_word();
      cycle();
      if (i == 9 || i == CMAX - 2 || i == CMAX + 7) begin
        n_total++;
        if (wr_count !== (AW+1)'(m_wcnt))
          $display("FAIL saturate at write %0d: cnt=%0d, want %0d", i + 1, wr_count, m_wcnt);
        else n_pass++;
      end
    end
    idle_inputs();
    n_total++;
    if (wr_count !== (AW+1)'(CMAX))
      $display("FAIL saturate_final: cnt=%0d, want %0d", wr_count, CMAX);
    else n_pass++;
  endtask

  task automatic test_reset_mid_sweep();
    clear_req = 1'b1; cycle(); clear_req = 1'b0;
    repeat (7) cycle();
    #2 reset_n = 1'b0;
    #1;
    n_total++;
    if (busy !== 1'b1 || clear_done !== 1'b0 || rdata0 !== '0 || rdata1 !== '0 ||
        oob_fault !== 1'b0 || wr_count !== '0)
      $display("FAIL reset_mid_sweep: busy=%0b done=%0b rd0=%h rd1=%h oob=%0b cnt=%0d, want 1 0 0 0 0 0",
               busy, clear_done, rdata0, rdata1, oob_fault, wr_count);
    else n_pass++;
    model_reset();
    @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_async_reset_idle();
    WE = 1'b1; waddr = 5'd7; wdata = rnd_word(); cycle();
    WE = 1'b0; raddr0 = 5'd7; raddr1 = 5'd30; cycle();
    n_total++;
    if (rdata0 !== m_rd0 || oob_fault !== 1'b1 || wr_count !== (AW+1)'(m_wcnt))
      $display("FAIL pre_reset: rd0=%h oob=%0b cnt=%0d, want %h 1 %0d", rdata0, oob_fault, wr_count, m_rd0, m_wcnt);
    else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_total++;
    if (busy !== 1'b1 || rdata0 !== '0 || oob_fault !== 1'b0 || wr_count !== '0)
      $display("FAIL async_reset: busy=%0b rd0=%h oob=%0b cnt=%0d, want 1 0 0 0", busy, rdata0, oob_fault, wr_count);
    else n_pass++;
    idle_inputs();
    model_reset();
    @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      clear_req = ($urandom_range(0, 39) == 0);
      WE = $urandom_range(0, 1) == 1;
      waddr = AW'($urandom_range(0, DP + 1));
      wdata = rnd_word();
      raddr0 = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, DP + 1));
      raddr1 = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, DP + 1));
      cycle();
      n_total++;
      if (rdata0 !== m_rd0 || rdata1 !== m_rd1 || busy !== (m_left > 0) || clear_done !== (m_left == 1) ||
          oob_fault !== m_oob || wr_count !== (AW+1)'(m_wcnt))
        $display("FAIL random cyc %0d: rd0=%h rd1=%h busy=%0b done=%0b oob=%0b cnt=%0d, want %h %h %0b %0b %0b %0d",
                 i, rdata0, rdata1, busy, clear_done, oob_fault, wr_count,
                 m_rd0, m_rd1, m_left > 0, m_left == 1, m_oob, m_wcnt);
      else n_pass++;
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < DP; i++) m_mem[i] = rnd_word();
    test_reset();
    test_sweep_length();
    test_write_read();
    test_bypass();
    test_oob();
    test_clear();
    test_saturate();
    test_reset_mid_sweep();
    test_sweep_length();
    test_async_reset_idle();
    test_sweep_length();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
